// File: rtl/receiver_rsa_blind_if.sv
// Request/result bundle between the receiver blinding stage and whatever drives it.
// master drives the job inputs; slave is the blinding stage itself.
interface receiver_rsa_blind_if;
   logic        gen;
   logic        choice;
   logic [31:0] k;
   logic [31:0] e;
   logic [31:0] N;
   logic [31:0] rand_val0;
   logic [31:0] rand_val1;
   logic [31:0] received_data;
   logic        gen_end;
   logic        busy;

   modport master (
      output gen, choice, k, e, N, rand_val0, rand_val1,
      input  received_data, gen_end, busy
   );

   modport slave (
      input  gen, choice, k, e, N, rand_val0, rand_val1,
      output received_data, gen_end, busy
   );
endinterface

// File: rtl/receiver_rsa_blind.sv
// Receiver-side OT blinding: v = (x_b + k^e) mod N, using one bit-serial modular
// multiplier shared by input reduction, multiply and square (right-to-left exponentiation).
module receiver_rsa_blind (
   input  logic                  clk,
   input  logic                  rstn,
   receiver_rsa_blind_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RED_K,
      S_RED_X,
      S_EXP_CHK,
      S_MULR,
      S_SQR,
      S_ADD
   } state_t;

   state_t      state, state_nx;

   logic [31:0] k_reg, e_reg, n_reg, x_reg;
   logic [31:0] base, xr, res;
   logic [31:0] acc;
   logic [4:0]  cnt;
   logic [31:0] received_data_r;
   logic        gen_end_r, busy_r;

   logic [31:0] op_a, op_b;
   logic        op_bit, last, mm_run, n_small;
   logic [32:0] n_ext, dbl, dbl_r, sum, add_s;
   logic [31:0] mm_res, add_res;

   assign bus.received_data = received_data_r;
   assign bus.gen_end       = gen_end_r;
   assign bus.busy          = busy_r;

   assign n_small = (n_reg < 32'd2);
   assign last    = (cnt == 5'd31);
   assign n_ext   = {1'b0, n_reg};

   // Multiplier operands come from the state; b is scanned MSB first via cnt.
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      mm_run = 1'b0;
      case (state)
         S_RED_K: begin op_a = 32'd1; op_b = k_reg; mm_run = !n_small; end
         S_RED_X: begin op_a = 32'd1; op_b = x_reg; mm_run = 1'b1;     end
         S_MULR:  begin op_a = res;   op_b = base;  mm_run = 1'b1;     end
         S_SQR:   begin op_a = base;  op_b = base;  mm_run = 1'b1;     end
         default: ;
      endcase
   end

   always_comb begin
      op_bit  = op_b[5'd31 - cnt];
      dbl     = {acc, 1'b0};
      dbl_r   = (dbl >= n_ext) ? dbl - n_ext : dbl;
      sum     = op_bit ? dbl_r + {1'b0, op_a} : dbl_r;
      mm_res  = 32'((sum >= n_ext) ? sum - n_ext : sum);
      add_s   = {1'b0, xr} + {1'b0, res};
      add_res = 32'((add_s >= n_ext) ? add_s - n_ext : add_s);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (bus.gen) state_nx = S_RED_K;
         // N<2 is judged on the latched value, so the bail-out happens one cycle in.
         S_RED_K:   if (n_small) state_nx = S_ADD;
                    else if (last) state_nx = S_RED_X;
         S_RED_X:   if (last) state_nx = S_EXP_CHK;
         S_EXP_CHK: if (e_reg == '0) state_nx = S_ADD;
                    else if (e_reg[0]) state_nx = S_MULR;
                    else state_nx = S_SQR;
         S_MULR:    if (last) state_nx = S_SQR;
         S_SQR:     if (last) state_nx = S_EXP_CHK;
         S_ADD:     state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         k_reg           <= '0;
         e_reg           <= '0;
         n_reg           <= '0;
         x_reg           <= '0;
         base            <= '0;
         xr              <= '0;
         res             <= '0;
         acc             <= '0;
         cnt             <= '0;
         received_data_r <= '0;
         gen_end_r       <= 1'b0;
         busy_r          <= 1'b0;
      end else begin
         gen_end_r <= 1'b0;

         if (mm_run) begin
            cnt <= cnt + 5'd1;
            acc <= last ? '0 : mm_res;
         end

         case (state)
            S_IDLE: if (bus.gen) begin
               k_reg  <= bus.k;
               e_reg  <= bus.e;
               n_reg  <= bus.N;
               x_reg  <= bus.choice ? bus.rand_val1 : bus.rand_val0;
               base   <= '0;
               xr     <= '0;
               res    <= '0;
               acc    <= '0;
               cnt    <= '0;
               busy_r <= 1'b1;
            end
            S_RED_K: if (mm_run && last) base <= mm_res;
            S_RED_X: if (last) begin
               xr  <= mm_res;
               res <= 32'd1;
            end
            S_MULR: if (last) res <= mm_res;
            S_SQR: if (last) begin
               base  <= mm_res;
               e_reg <= e_reg >> 1;
            end
            S_ADD: begin
               received_data_r <= add_res;
               gen_end_r       <= 1'b1;
               busy_r          <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_receiver_rsa_blind.sv
// Directed checks of receiver_rsa_blind: results, completion latency, busy/gen_end
// behaviour, ignored requests while busy, asynchronous abort and back-to-back start.
module tb_receiver_rsa_blind;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   receiver_rsa_blind_if bus();

   receiver_rsa_blind dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic set_job(input logic ch, input logic [31:0] kk, input logic [31:0] ee,
                          input logic [31:0] nn, input logic [31:0] x0, input logic [31:0] x1);
      bus.choice    = ch;
      bus.k         = kk;
      bus.e         = ee;
      bus.N         = nn;
      bus.rand_val0 = x0;
      bus.rand_val1 = x1;
   endtask

   task automatic kick(input logic ch, input logic [31:0] kk, input logic [31:0] ee,
                       input logic [31:0] nn, input logic [31:0] x0, input logic [31:0] x1);
      @(negedge clk);
      set_job(ch, kk, ee, nn, x0, x1);
      bus.gen = 1'b1;
   endtask

   // Assumes gen is already high ahead of the next edge (E0).
   task automatic wait_done(input string tag, input logic [31:0] exp_v,
                            input int unsigned exp_lat, input bit poke, input bit chain);
      int unsigned cyc = 0;
      bit busy_ok = 1'b1;
      bit seen    = 1'b0;
      @(posedge clk);
      #1;
      bus.gen = 1'b0;
      check_val({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
      while (!seen && cyc < 1000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.gen_end) seen = 1'b1;
         else if (!bus.busy) busy_ok = 1'b0;
         if (poke && (cyc == 10 || cyc == 100)) begin
            bus.gen = 1'b1;
            set_job(1'b1, 32'd7, 32'd3, 32'd99, 32'd11, 32'd1);
         end else begin
            bus.gen = 1'b0;
         end
      end
      check_val({tag, "_lat"}, cyc, exp_lat);
      check_val({tag, "_data"}, bus.received_data, exp_v);
      check_val({tag, "_busy_hold"}, 32'(busy_ok), 32'd1);
      check_val({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      if (!chain) begin
         @(posedge clk);
         #1;
         check_val({tag, "_pulse"}, 32'(bus.gen_end), 32'd0);
      end
   endtask

   initial begin
      bit quiet;
      bus.gen = 1'b0;
      set_job(1'b0, '0, '0, '0, '0, '0);
      #12;
      check_val("rst_data", bus.received_data, 32'd0);
      check_val("rst_gen_end", 32'(bus.gen_end), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      kick(1'b1, 32'd65, 32'd17, 32'd3233, 32'd0, 32'd1000);
      wait_done("rsa17", 32'd557, 295, 1'b0, 1'b0);

      kick(1'b0, 32'd65, 32'd0, 32'd3233, 32'd3232, 32'd0);
      wait_done("e0_wrap", 32'd0, 66, 1'b0, 1'b0);

      kick(1'b0, 32'd3298, 32'd17, 32'd3233, 32'd6471, 32'd0);
      wait_done("unreduced", 32'd2795, 295, 1'b0, 1'b0);

      kick(1'b0, 32'd2, 32'd31, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0);
      wait_done("full_width", 32'h7FFF_FFFF, 391, 1'b0, 1'b0);

      kick(1'b1, 32'd65, 32'd17, 32'd3233, 32'd0, 32'd1000);
      wait_done("gen_ignored", 32'd557, 295, 1'b1, 1'b0);

      // Abort inside the first MULR pass (edges E0+66..E0+97).
      kick(1'b1, 32'd65, 32'd17, 32'd3233, 32'd0, 32'd1000);
      @(posedge clk);
      #1;
      bus.gen = 1'b0;
      repeat (80) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_val("abort_data", bus.received_data, 32'd0);
      check_val("abort_gen_end", 32'(bus.gen_end), 32'd0);
      check_val("abort_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn  = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (bus.gen_end || bus.busy) quiet = 1'b0;
      end
      check_val("abort_quiet", 32'(quiet), 32'd1);

      kick(1'b1, 32'd65, 32'd17, 32'd3233, 32'd0, 32'd1000);
      wait_done("restart", 32'd557, 295, 1'b0, 1'b0);

      kick(1'b1, 32'd123, 32'd5, 32'd1, 32'd9, 32'd77);
      wait_done("n_one", 32'd0, 2, 1'b0, 1'b1);
      set_job(1'b1, 32'd0, 32'd0, 32'd3233, 32'd0, 32'd5);
      bus.gen = 1'b1;
      wait_done("back2back", 32'd6, 66, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/receiver_rsa_blind.md
# receiver_rsa_blind

Receiver-side blinding stage of the RSA oblivious-transfer exchange: computes the value the sender's packing stage consumes as `received_data`, v = (x_b + k^e) mod N, where x_b is the sender random value selected by the receiver's choice bit and k is the receiver's secret. It sits directly upstream of the sender packing stage. It is self-contained: one bit-serial interleaved modular multiplier is time-shared for input reduction, multiply and square, driven by a right-to-left binary exponentiation FSM.

## Interface
- No parameters; all datapaths fixed at 32 bits, internal sums 33 bits.
- `clk` input 1 — single clock, rising edge.
- `rstn` input 1 — reset, asynchronous, active-low.
- `gen` input 1 — start request, sampled in IDLE only.
- `choice` input 1 — receiver choice b (0 selects `rand_val0`, 1 selects `rand_val1`).
- `k` input 32 — receiver secret.
- `e` input 32 — public exponent.
- `N` input 32 — modulus.
- `rand_val0`, `rand_val1` input 32 — sender random values x0, x1.
- `received_data` output 32 — v, held until next completion.
- `gen_end` output 1 — one-cycle completion pulse.
- `busy` output 1 — high while computing.

## Operation
- Reset (async): state IDLE; `received_data`=0, `gen_end`=0, `busy`=0; all internal registers 0.
- IDLE + `gen`=1 at edge E0: latch k, e, N, x=(choice ? rand_val1 : rand_val0); `busy`←1. If latched N<2, go to ADD with xr=0, res=0; else go to RED_K.
- mulmod(a,b), with a<N: 32 cycles, b MSB first; per cycle acc←2·acc, subtract N if ≥N; if b bit set, acc←acc+a, subtract N if ≥N. All intermediates are 33-bit; valid for any N in [2, 2^32−1].
- RED_K: base←mulmod(1,k) = k mod N (32 cycles) → RED_X.
- RED_X: xr←mulmod(1,x) (32 cycles); res←1 → EXP_CHK.
- EXP_CHK (1 cycle): e_reg==0 → ADD; e_reg[0]==1 → MULR; else → SQR.
- MULR: res←mulmod(res,base) (32 cycles) → SQR.
- SQR: base←mulmod(base,base) (32 cycles); e_reg←e_reg>>1 → EXP_CHK.
- ADD (1 cycle): s=xr+res (33-bit); `received_data`←(s≥N ? s−N : s); `gen_end`←1; `busy`←0 → IDLE.
- Inputs may be ≥N; they are reduced before use. e=0 yields v=(x+1) mod N.

## Timing
- With m = bit length of e (0 when e=0) and e_i its bits, `gen_end` rises at edge E0 + 66 + Σ_{i<m}(33 + 32·e_i).
- N<2: `gen_end` rises at E2, `received_data`=0.
- `gen_end` is high exactly one cycle. `busy` is high from E0 through the edge that raises `gen_end`, and is low in the same cycle `gen_end` is high.
- `gen` while busy (any level or duration) is ignored; inputs may change freely after E0.
- `gen` in the cycle `gen_end` is high is accepted, since the state is IDLE.
- `rstn` low mid-operation aborts immediately; outputs return to reset values, and no `gen_end` is produced for the aborted job.

## Test plan
- N=3233, e=17, k=65, choice=1, rand_val1=1000 → `received_data`=557 (65^17 mod 3233=2790), `gen_end` at E0+295, `busy` high E0..E0+295.
- N=3233, e=0, choice=0, rand_val0=3232 → `received_data`=0 (wrap-around), `gen_end` at E0+66.
- Unreduced inputs: N=3233, e=17, k=3298, choice=0, rand_val0=6471 → `received_data`=2795, `gen_end` at E0+295.
- Full width: N=0xFFFFFFFB, e=31, k=2, choice=0, rand_val0=0xFFFFFFFA → `received_data`=0x7FFFFFFF, `gen_end` at E0+391.
- Pulse `gen` with altered inputs at E0+10 and E0+100 of the first scenario → result unchanged, single `gen_end`. Then assert `rstn` low mid-MULR → `received_data`=0, `gen_end`=0, `busy`=0 asynchronously. Restart the first scenario → 557 at E0+295.
- N=1, any k/e/x → `received_data`=0, `gen_end` at E0+2. A back-to-back `gen` in the `gen_end` cycle is accepted.
